// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch slice.
package fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic {HALT, RUN} fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Decode-side valid/ready handshake carrying an instruction and its address.
interface fetch_if;
  import fetch_pkg::*;

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (output if_valid, if_instr, if_pc, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer; flush wins over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  fetch_entry_t     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries data only; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch controller: owns the PC, drives the 1-cycle-latency ROM and buffers returns.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
  parameter int                FIFO_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              halted,
  fetch_if.master           dec
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              inflight;
  logic              deq;
  logic              issue;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  fetch_entry_t      ret_entry;
  fetch_entry_t      head;

  assign deq       = dec.if_valid && dec.if_ready;
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(deq);
  // A redirect flushes the buffer, so it always has room for the target fetch.
  assign issue     = (state == RUN) && run &&
                     (redirect_valid || (occupancy < (CNT_W + 1)'(FIFO_DEPTH)));
  assign rom_addr  = redirect_valid ? redirect_pc : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HALT;
      pc       <= RESET_VECTOR;
      inflight <= 1'b0;
      halted   <= 1'b1;
    end else begin
      case (state)
        HALT:    if (run)  state <= RUN;
        RUN:     if (!run) state <= HALT;
        default: state <= HALT;
      endcase
      inflight <= issue;
      if (issue)               pc <= rom_addr + 1'b1;
      else if (redirect_valid) pc <= redirect_pc;
      // Low run means HALT next cycle and no issue now, hence nothing in flight.
      halted <= !run;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fetch_pc_q <= rom_addr;
  end

  assign ret_entry = '{instr: rom_data, pc: fetch_pc_q};

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (ret_entry),
    .count (count),
    .head  (head)
  );

  assign dec.if_valid = (count != '0);
  assign dec.if_instr = head.instr;
  assign dec.if_pc    = head.pc;
endmodule
